noise_channel_p: RTL and testbench

NOISE_CHANNEL_P -- requirements
Module: noise_channel_p

---
 rtl/noise_channel_p_pkg.sv | 21 ++
 rtl/noise_channel_p_lfsr.sv | 31 +++
 rtl/noise_channel_p.sv | 131 +++++++++++++
 tb/tb_noise_channel_p.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/noise_channel_p_pkg.sv
// Shared definitions for the noisy symbol channel: FSM encoding, LFSR
// polynomial, default seed and the LFSR step function.
package noise_channel_p_pkg;

    // 3-bit encoding kept identical in width to the existing channel state
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_EMIT = 3'd2,
        ST_DONE = 3'd3
    } chan_state_e;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY    = 16'hB400;
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/noise_channel_p_lfsr.sv
// Free-running 16-bit Galois LFSR used as the channel noise source.
module channel_lfsr
    import noise_channel_p_pkg::*;
#(
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] lfsr_state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    // Next LFSR value, advanced unconditionally every cycle
    always_comb begin
        state_d = lfsr_next(state_q);
    end

    // State register, reloaded with the seed while reset is held
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign lfsr_state = state_q;

endmodule

// File: rtl/noise_channel_p.sv
// Noisy channel: emits SPS saturated samples of sym*AMP plus LFSR noise for
// each symbol requested through a four-phase chan_start/chan_done handshake.
module noise_channel_p
    import noise_channel_p_pkg::*;
#(
    parameter int          OUT_W   = 12,
    parameter int          AMP     = 256,
    parameter int          NOISE_W = 7,
    parameter int          SPS     = 4,
    parameter logic [15:0] SEED    = SEED_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chan_start,
    input  logic signed [1:0]       trans_out,
    input  logic                    noise_en,
    input  logic [2:0]              noise_shift,
    output logic signed [OUT_W-1:0] chan_out,
    output logic                    sample_valid,
    output logic                    chan_done
);

    localparam int SUM_W = OUT_W + 2;
    localparam logic signed [SUM_W-1:0] MAX_V = SUM_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] MIN_V = ~MAX_V;
    localparam logic signed [SUM_W-1:0] AMP_S = SUM_W'(AMP);

    if (AMP < 1 || AMP > (2 ** (OUT_W - 1)) - 1) begin : g_bad_amp
        $error("noise_channel_p: AMP out of range");
    end
    if (SPS < 1 || SPS > 255) begin : g_bad_sps
        $error("noise_channel_p: SPS out of range");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("noise_channel_p: SEED must be nonzero");
    end
    if (2 * NOISE_W > 16 || NOISE_W >= OUT_W) begin : g_bad_noise_w
        $error("noise_channel_p: NOISE_W too wide");
    end

    function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [SUM_W-1:0] v);
        if (v > MAX_V) begin
            return MAX_V[OUT_W-1:0];
        end else if (v < MIN_V) begin
            return MIN_V[OUT_W-1:0];
        end
        return v[OUT_W-1:0];
    endfunction

    chan_state_e               state_q, state_d;
    logic [7:0]                cnt_q, cnt_d;
    logic signed [1:0]         sym_q, sym_d;
    logic signed [OUT_W-1:0]   chan_out_q, chan_out_d;
    logic [15:0]               lfsr_state;
    logic signed [NOISE_W-1:0] s0, s1;
    logic signed [NOISE_W:0]   nsum, nshift;
    logic signed [SUM_W-1:0]   noise_ext, sym_amp;
    logic signed [OUT_W-1:0]   sample;

    channel_lfsr #(.SEED(SEED)) u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .lfsr_state (lfsr_state)
    );

    // Sample datapath: two signed LFSR slices summed, attenuated, added to sym*AMP
    always_comb begin
        s0        = NOISE_W'(lfsr_state);
        s1        = NOISE_W'(lfsr_state >> NOISE_W);
        nsum      = (NOISE_W + 1)'(s0) + (NOISE_W + 1)'(s1);
        nshift    = nsum >>> noise_shift;
        noise_ext = noise_en ? SUM_W'(nshift) : {SUM_W{1'b0}};
        sym_amp   = SUM_W'(sym_q) * AMP_S;
        sample    = sat_out(sym_amp + noise_ext);
    end

    // Next-state logic for the symbol FSM, counter, symbol latch and output hold
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sym_d      = sym_q;
        chan_out_d = chan_out_q;
        case (state_q)
            ST_IDLE: begin
                if (chan_start) begin
                    state_d = ST_LOAD;
                    sym_d   = trans_out;
                end
            end
            ST_LOAD: begin
                cnt_d   = 8'd0;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                chan_out_d = sample;
                cnt_d      = cnt_q + 8'd1;
                if (cnt_q == 8'(SPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!chan_start) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registers; reset aborts any symbol in flight and clears the output
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            sym_q      <= 2'sd0;
            chan_out_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sym_q      <= sym_d;
            chan_out_q <= chan_out_d;
        end
    end

    assign chan_out     = (state_q == ST_EMIT) ? sample : chan_out_q;
    assign sample_valid = (state_q == ST_EMIT);
    assign chan_done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_noise_channel_p.sv
// Bench for noise_channel_p: a default instance (AMP=256) and a saturating
// instance (AMP=2047) share stimulus and are checked against a sample model.
module tb_noise_channel_p;

    localparam int SPS     = 4;
    localparam int AMP_A   = 256;
    localparam int AMP_B   = 2047;
    localparam int NOCONST = 99999;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               chan_start = 1'b0;
    logic signed [1:0]  trans_out = 2'sd0;
    logic               noise_en = 1'b0;
    logic [2:0]         noise_shift = 3'd0;
    logic signed [11:0] out_a, out_b;
    logic               vld_a, vld_b, done_a, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    noise_channel_p #(.OUT_W(12), .AMP(AMP_A), .NOISE_W(7), .SPS(SPS), .SEED(16'hACE1)) dut_a (
        .clk(clk), .reset(reset), .chan_start(chan_start), .trans_out(trans_out),
        .noise_en(noise_en), .noise_shift(noise_shift), .chan_out(out_a),
        .sample_valid(vld_a), .chan_done(done_a)
    );

    noise_channel_p #(.OUT_W(12), .AMP(AMP_B), .NOISE_W(7), .SPS(SPS), .SEED(16'hACE1)) dut_b (
        .clk(clk), .reset(reset), .chan_start(chan_start), .trans_out(trans_out),
        .noise_en(noise_en), .noise_shift(noise_shift), .chan_out(out_b),
        .sample_valid(vld_b), .chan_done(done_b)
    );

    // Reference noise source: Galois LFSR x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] gal_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= gal_step(m_lfsr);
    end

    // Expected sample from plain integer arithmetic
    function automatic int model(input int sym, input int amp, input logic [15:0] l,
                                 input bit en, input int sh);
        int s0, s1, n, v;
        s0 = int'(l[6:0]);
        if (s0 >= 64) s0 -= 128;
        s1 = int'(l[13:7]);
        if (s1 >= 64) s1 -= 128;
        n = en ? ((s0 + s1) >>> sh) : 0;
        v = sym * amp + n;
        if (v > 2047)  v = 2047;
        if (v < -2048) v = -2048;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full handshake. hold=0 drops start during LOAD; otherwise start stays
    // high for hold DONE cycles. ca/cb force a constant expectation per instance.
    task automatic run_symbol(input int sym, input bit en, input int sh, input int hold,
                              input int ca, input int cb);
        int ea, eb, la, lb, d;
        la = 0; lb = 0;
        @(negedge clk);
        trans_out   = 2'(sym);
        noise_en    = en;
        noise_shift = 3'(sh);
        chan_start  = 1'b1;
        @(negedge clk);
        chk("load_vld", vld_a, 0);
        chk("load_done", done_a, 0);
        chk("load_vld_b", vld_b, 0);
        trans_out = 2'($urandom_range(0, 3));
        if (hold == 0) chan_start = 1'b0;
        for (int k = 0; k < SPS; k++) begin
            @(negedge clk);
            ea = (ca == NOCONST) ? model(sym, AMP_A, m_lfsr, en, sh) : ca;
            eb = (cb == NOCONST) ? model(sym, AMP_B, m_lfsr, en, sh) : cb;
            chk("emit_vld", vld_a, 1);
            chk("emit_done", done_a, 0);
            chk("emit_out", out_a, ea);
            chk("emit_vld_b", vld_b, 1);
            chk("emit_out_sat", out_b, eb);
            if (en && sh == 7) begin
                d = int'(out_a) - sym * AMP_A;
                chk("noise_mag_shift7", (d <= 1 && d >= -1), 1);
            end
            la = ea;
            lb = eb;
        end
        for (int c = 0; c < ((hold == 0) ? 1 : hold); c++) begin
            @(negedge clk);
            chk("done_flag", done_a, 1);
            chk("done_vld", vld_a, 0);
            chk("done_hold_out", out_a, la);
            chk("done_flag_b", done_b, 1);
            chk("done_hold_out_b", out_b, lb);
        end
        chan_start = 1'b0;
        @(negedge clk);
        chk("idle_done", done_a, 0);
        chk("idle_vld", vld_a, 0);
        chk("idle_hold_out", out_a, la);
        chk("idle_done_b", done_b, 0);
    endtask

    typedef struct {
        int sym;
        int hold;
        int exp_a;
        int exp_b;
    } vec_t;

    vec_t tbl[6];

    initial begin
        // noise disabled: fixed amplitudes, including -2 and saturation on dut_b
        tbl[0] = '{sym:  1, hold: 55,      exp_a:  256, exp_b:  2047};
        tbl[1] = '{sym: -1, hold: 1,       exp_a: -256, exp_b: -2047};
        tbl[2] = '{sym:  0, hold: 1,       exp_a:    0, exp_b:     0};
        tbl[3] = '{sym: -2, hold: 2,       exp_a: -512, exp_b: -2048};
        tbl[4] = '{sym:  1, hold: 3 * SPS, exp_a:  256, exp_b:  2047};
        tbl[5] = '{sym: -1, hold: 0,       exp_a: -256, exp_b: -2047};

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_out", out_a, 0);
        chk("rst_vld", vld_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_out_b", out_b, 0);
        reset = 1'b0;

        // first symbol right after reset exercises the seed value
        run_symbol(1, 1'b1, 0, 1, NOCONST, NOCONST);

        for (int i = 0; i < 6; i++) begin
            run_symbol(tbl[i].sym, 1'b0, 0, tbl[i].hold, tbl[i].exp_a, tbl[i].exp_b);
        end

        // full-scale amplitude with noise: high side clamps, -2 pins at the floor
        run_symbol(1, 1'b1, 0, 1, NOCONST, NOCONST);
        run_symbol(-2, 1'b1, 0, 1, NOCONST, -2048);
        run_symbol(-1, 1'b1, 0, 2, NOCONST, NOCONST);

        // reset on the second EMIT cycle
        @(negedge clk);
        trans_out = 2'sd1; noise_en = 1'b0; noise_shift = 3'd0; chan_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_out", out_a, 256);
        @(negedge clk);
        chk("pre_rst_vld", vld_a, 1);
        reset = 1'b1;
        chan_start = 1'b0;
        @(negedge clk);
        chk("midrst_out", out_a, 0);
        chk("midrst_vld", vld_a, 0);
        chk("midrst_done", done_a, 0);
        chk("midrst_out_b", out_b, 0);
        reset = 1'b0;
        for (int c = 0; c < SPS + 2; c++) begin
            @(negedge clk);
            chk("postrst_no_done", done_a, 0);
            chk("postrst_no_vld", vld_a, 0);
        end

        // randomized symbols: shift 0 then shift 7
        for (int i = 0; i < 1000; i++) begin
            run_symbol(int'($urandom_range(0, 3)) - 2, ($urandom_range(0, 7) != 0),
                       (i < 500) ? 0 : 7, int'($urandom_range(0, 3)), NOCONST, NOCONST);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got time limit, expected end of test");
        $fatal(1, "bench time limit reached");
    end

endmodule
